// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM and its helpers.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // States that sit on the memory handshake and may stall.
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles in a memory state and flags a timeout.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_waiting,
  output logic o_timeout
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Timeout fires when the counter has already seen MEM_TIMEOUT stalls and
  // this cycle stalls again; a ready in that cycle suppresses it.
  assign o_timeout = (MEM_TIMEOUT != 0) && i_waiting && (r_cnt == CW'(MEM_TIMEOUT));

  // Count stalls; any non-stall cycle (ready or state change) clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (i_waiting && !o_timeout) r_cnt <= r_cnt + 1'b1;
    else                            r_cnt <= '0;
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style multicycle MIPS control FSM with retire counter and traps.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int RETIRED_W   = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic [1:0]           PCSource,
  output logic                 IorD,
  output logic                 MemoryRead,
  output logic                 MemoryWrite,
  output logic                 IRWrite,
  output logic                 MemoryToRegister,
  output logic                 RegistroDestino,
  output logic                 RegisterWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOpcode,
  output logic                 instr_done,
  output logic [RETIRED_W-1:0] retired,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [3:0]           state_o
);

  state_t                r_state;
  logic [RETIRED_W-1:0]  r_retired;
  logic                  r_trap;
  logic [1:0]            r_cause;
  logic                  w_waiting;
  logic                  w_timeout;
  logic                  w_done;

  assign w_waiting = is_mem_wait_state(r_state) && !mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_waiting (w_waiting),
    .o_timeout (w_timeout)
  );

  // Last cycle of every instruction; sw only ends once the write is accepted.
  assign w_done = (r_state == S_MEM_WB) || (r_state == S_R_WB) ||
                  (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                  (r_state == S_I_WB) ||
                  ((r_state == S_MEM_WRITE) && mem_ready);

  // State sequencing, retire counting and sticky trap capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
      r_trap    <= 1'b0;
      r_cause   <= CAUSE_NONE;
    end else begin
      if (w_done) r_retired <= r_retired + 1'b1;
      if (w_timeout) begin
        r_state <= S_TRAP;
        r_trap  <= 1'b1;
        r_cause <= CAUSE_TIMEOUT;
      end else begin
        case (r_state)
          S_FETCH:     if (mem_ready) r_state <= S_DECODE;
          S_DECODE: begin
            case (opcode)
              OP_RTYPE:     r_state <= S_R_EXEC;
              OP_LW, OP_SW: r_state <= S_MEM_ADDR;
              OP_BEQ:       r_state <= S_BRANCH;
              OP_J:         r_state <= S_JUMP;
              OP_ADDI:      r_state <= S_I_EXEC;
              default: begin
                r_state <= S_TRAP;
                r_trap  <= 1'b1;
                r_cause <= CAUSE_ILLEGAL;
              end
            endcase
          end
          S_MEM_ADDR:  r_state <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
          S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
          S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
          S_R_EXEC:    r_state <= S_R_WB;
          S_I_EXEC:    r_state <= S_I_WB;
          S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: r_state <= S_FETCH;
          default:     r_state <= S_TRAP;  // TRAP holds; stray encodings park here too
        endcase
      end
    end
  end

  // Control decode from the current state; IRWrite/PCWrite in FETCH track mem_ready.
  always_comb begin
    PCWrite          = 1'b0;
    PCWriteCond      = 1'b0;
    PCSource         = PCSRC_ALU;
    IorD             = 1'b0;
    MemoryRead       = 1'b0;
    MemoryWrite      = 1'b0;
    IRWrite          = 1'b0;
    MemoryToRegister = 1'b0;
    RegistroDestino  = 1'b0;
    RegisterWrite    = 1'b0;
    ALUSrcA          = 1'b0;
    ALUSrcB          = SRCB_RT;
    ALUOpcode        = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        MemoryRead = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
      end
      S_DECODE:    ALUSrcB = SRCB_IMM_SH;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_READ: begin
        MemoryRead = 1'b1;
        IorD       = 1'b1;
      end
      S_MEM_WB: begin
        RegisterWrite    = 1'b1;
        MemoryToRegister = 1'b1;
      end
      S_MEM_WRITE: begin
        MemoryWrite = 1'b1;
        IorD        = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOpcode = ALUOP_FUNCT;
      end
      S_R_WB: begin
        RegisterWrite   = 1'b1;
        RegistroDestino = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOpcode   = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_I_WB:      RegisterWrite = 1'b1;
      default: ;
    endcase
  end

  assign instr_done = w_done;
  assign retired    = r_retired;
  assign trap       = r_trap;
  assign trap_cause = r_cause;
  assign state_o    = r_state;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the MIPS datapath (register file, ALU, data/instruction memory, PC muxes) as a classic multicycle machine.
- It replaces the single-cycle CONTROL block's flat decode.
- It consumes the IR opcode and a memory-ready handshake, and drives every mux select and write enable.
- It also counts retired instructions and traps on illegal opcodes or memory timeouts.

Parameters:
- RETIRED_W, 32: width of the retired-instruction counter; wraps modulo 2^RETIRED_W.
- MEM_TIMEOUT, 15: maximum consecutive wait cycles in any memory state before trapping; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26]; stable from DECODE until the instruction completes.
- mem_ready  in  1  memory handshake; the access completes in the cycle it is 1.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load when ALU zero (beq).
- PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemoryRead  out  1  memory read strobe.
- MemoryWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemoryToRegister  out  1  write-back select: 1 = MDR.
- RegistroDestino  out  1  write register select: 1 = rd, 0 = rt.
- RegisterWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 rt, 01 constant 4, 10 sign-extended immediate, 11 immediate<<2.
- ALUOpcode  out  2  00 add, 01 sub, 10 funct-decoded.
- instr_done  out  1  high during the last cycle of each instruction.
- retired  out  RETIRED_W  count of completed instructions.
- trap  out  1  sticky; high in TRAP.
- trap_cause  out  2  01 illegal opcode, 10 memory timeout; 00 otherwise.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- State encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12
- Reset (asynchronous):
  - state=FETCH, retired=0, trap=0, trap_cause=00, wait counter=0.
  - Outputs therefore show FETCH values: MemoryRead=1, ALUSrcB=01; IRWrite and PCWrite follow mem_ready; all others 0.
- Unlisted outputs are 0 in every state.
- FETCH:
  - MemoryRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOpcode=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready (the only Mealy outputs).
  - Goes to DECODE when mem_ready=1, else stays.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOpcode=00.
  - Next state by opcode: 000000 -> R_EXEC; 100011 (lw) or 101011 (sw) -> MEM_ADDR; 000100 (beq) -> BRANCH; 000010 (j) -> JUMP; 001000 (addi) -> I_EXEC.
  - Any other opcode -> TRAP with cause 01.
- MEM_ADDR:
  - ALUSrcA=1, ALUSrcB=10, ALUOpcode=00.
  - Goes to MEM_READ if lw, MEM_WRITE if sw.
- MEM_READ:
  - MemoryRead=1, IorD=1.
  - Goes to MEM_WB when mem_ready=1.
- MEM_WB:
  - RegisterWrite=1, MemoryToRegister=1, RegistroDestino=0.
  - Goes to FETCH.
- MEM_WRITE:
  - MemoryWrite=1, IorD=1.
  - Goes to FETCH when mem_ready=1.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOpcode=10; goes to R_WB.
- R_WB: RegisterWrite=1, RegistroDestino=1; goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOpcode=01, PCWriteCond=1, PCSource=01; goes to FETCH.
- JUMP: PCWrite=1, PCSource=10; goes to FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOpcode=00; goes to I_WB.
- I_WB: RegisterWrite=1, RegistroDestino=0, MemoryToRegister=0; goes to FETCH.
- TRAP: all datapath strobes 0, trap=1; stays until rst.
- Wait counter:
  - Increments each cycle in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP with cause 10.
  - mem_ready=1 in that same cycle wins: normal advance, no trap.
- instr_done:
  - Combinational 1 in MEM_WB, R_WB, BRANCH, JUMP, I_WB, and in MEM_WRITE when mem_ready=1.
  - retired increments on that clock edge and wraps from all-ones to 0.
- Instruction latencies with zero wait states:
  - lw 5 cycles; sw, R-type and addi 4; beq and j 3.
- rst asserted mid-instruction aborts it immediately: no instr_done, counter cleared.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - ALUSrcB, PCSource and ALUOpcode select constants;
  - trap cause codes.
- One sub-module, mem_wait_timer: wait counter plus timeout compare.
- Output decode stays in the FSM module.

Test Plan:
- Reset, then mem_ready=1 always, opcode=100011 (lw) -> state sequence 0,1,2,3,4,0; RegisterWrite and MemoryToRegister high only in state 4; retired=1 after 5 cycles.
- R-type (000000) then beq (000100) then j (000010), mem_ready=1 -> 4+3+3 cycles; PCWriteCond only in BRANCH; PCSource=10 with PCWrite in JUMP; retired=3.
- sw with mem_ready low for 3 cycles in MEM_WRITE -> MemoryWrite held 4 cycles; instr_done and retired+1 only in the ready cycle; total latency 7.
- opcode=111111 -> DECODE goes to TRAP; trap=1, trap_cause=01; all strobes 0 for 20 cycles; rst clears to FETCH.
- FETCH with mem_ready=0 for 16 cycles, MEM_TIMEOUT=15 -> TRAP with cause 10. Repeat with mem_ready=1 exactly on the 15th wait cycle -> DECODE, no trap.
- rst pulse while in MEM_READ -> asynchronous return to FETCH, retired=0, no instr_done; RETIRED_W=4 run of 17 instructions -> retired=1.
